// File: rtl/bus_responder_pkg.sv
// bus_responder_pkg
// Shared definitions for the CPU bus responder: memory region encoding,
// region boundary constants and the responder FSM state encoding.
// Configuration macro: ECHO_RAM_EN (adds the echo-RAM window constants).
package bus_responder_pkg;

    // Region code as seen on o_Mem_Region
    typedef enum logic [1:0] {
        REG_ROM  = 2'd0,
        REG_WRAM = 2'd1,
        REG_HRAM = 2'd2,
        REG_NONE = 2'd3
    } region_e;

    // Responder FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    // ROM starts at address 0, so only its upper bound is needed
    localparam logic [15:0] ROM_HI  = 16'h7FFF;
    localparam logic [15:0] WRAM_LO = 16'hC000;
    localparam logic [15:0] WRAM_HI = 16'hDFFF;
    localparam logic [15:0] HRAM_LO = 16'hFF80;
    localparam logic [15:0] HRAM_HI = 16'hFFFE;
`ifdef ECHO_RAM_EN
    // Echo window mirrors WRAM one 8 KiB page lower
    localparam logic [15:0] ECHO_LO     = 16'hE000;
    localparam logic [15:0] ECHO_HI     = 16'hFDFF;
    localparam logic [15:0] ECHO_OFFSET = 16'h2000;
`endif

    // Value returned for reads that reach no memory
    localparam logic [7:0] DATA_UNMAPPED = 8'hFF;

endpackage

// File: rtl/bus_region_decode.sv
// bus_region_decode
// Combinational address decoder: classifies a CPU address into a memory
// region and produces the address presented to memory.
// Ports:
//   i_Address  in  16  CPU address
//   o_Region   out 2   decoded region (ROM, WRAM, HRAM, none)
//   o_Mem_Addr out 16  translated memory address
// Configuration macro: ECHO_RAM_EN (E000-FDFF aliases WRAM at address-2000h).
module bus_region_decode
    import bus_responder_pkg::*;
(
    input  logic [15:0] i_Address,
    output region_e     o_Region,
    output logic [15:0] o_Mem_Addr
);

    // Region lookup and address translation
    always_comb begin
        o_Region   = REG_NONE;
        o_Mem_Addr = i_Address;
        if (i_Address <= ROM_HI) begin
            o_Region = REG_ROM;
        end else if (i_Address >= WRAM_LO && i_Address <= WRAM_HI) begin
            o_Region = REG_WRAM;
`ifdef ECHO_RAM_EN
        end else if (i_Address >= ECHO_LO && i_Address <= ECHO_HI) begin
            o_Region   = REG_WRAM;
            o_Mem_Addr = i_Address - ECHO_OFFSET;
`endif
        end else if (i_Address >= HRAM_LO && i_Address <= HRAM_HI) begin
            o_Region = REG_HRAM;
        end else begin
            o_Region = REG_NONE;
        end
    end

endmodule

// File: rtl/bus_responder.sv
// bus_responder
// Accepts single CPU bus transactions, decodes the target region and either
// forwards them to memory (waiting for an ack, with timeout) or answers them
// locally (unmapped reads return FFh, unmapped/ROM writes are discarded).
// Ports:
//   i_Clk, i_Reset_n                 clock, async active-low reset
//   i_Address_Out/i_Address          CPU request strobe and address
//   i_Bus_In/i_Bus_Out/i_Data        CPU read / write select, write data
//   o_Data, o_Ready, o_Error         read data, completion and error pulses
//   o_Mem_Req/We/Addr/Wdata/Region   memory request side (held until ack)
//   i_Mem_Ack, i_Mem_Rdata           memory completion and read data
// Parameter TIMEOUT_CYCLES: WAIT cycles allowed before giving up on an ack.
// Configuration macro: ECHO_RAM_EN (see bus_region_decode).
module bus_responder
    import bus_responder_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 8
) (
    input  logic        i_Clk,
    input  logic        i_Reset_n,
    input  logic        i_Address_Out,
    input  logic [15:0] i_Address,
    input  logic        i_Bus_In,
    input  logic        i_Bus_Out,
    input  logic [7:0]  i_Data,
    output logic [7:0]  o_Data,
    output logic        o_Ready,
    output logic        o_Error,
    output logic        o_Mem_Req,
    output logic        o_Mem_We,
    output logic [15:0] o_Mem_Addr,
    output logic [7:0]  o_Mem_Wdata,
    output logic [1:0]  o_Mem_Region,
    input  logic        i_Mem_Ack,
    input  logic [7:0]  i_Mem_Rdata
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e             state_q, state_d;
    logic [15:0]        addr_q, addr_d;
    logic               is_read_q, is_read_d;
    logic [7:0]         cpu_wdata_q, cpu_wdata_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         data_q, data_d;
    logic               ready_q, ready_d;
    logic               error_q, error_d;
    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic [15:0]        mem_addr_q, mem_addr_d;
    logic [7:0]         mem_wdata_q, mem_wdata_d;
    region_e            mem_region_q, mem_region_d;

    region_e            dec_region;
    logic [15:0]        dec_addr;

    bus_region_decode u_decode (
        .i_Address  (addr_q),
        .o_Region   (dec_region),
        .o_Mem_Addr (dec_addr)
    );

    // Next-state and output computation; o_Ready is raised on entry to RESP
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        is_read_d    = is_read_q;
        cpu_wdata_d  = cpu_wdata_q;
        cnt_d        = cnt_q;
        data_d       = data_q;
        ready_d      = 1'b0;
        error_d      = 1'b0;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_region_d = mem_region_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (i_Address_Out) begin
                    if (i_Bus_In ^ i_Bus_Out) begin
                        addr_d      = i_Address;
                        is_read_d   = i_Bus_In;
                        cpu_wdata_d = i_Data;
                        state_d     = ST_DECODE;
                    end else begin
                        // Ambiguous direction: flag it and stay idle
                        error_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DECODE: begin
                // Writes to ROM never reach memory
                if (dec_region != REG_NONE && (is_read_q || dec_region != REG_ROM)) begin
                    mem_req_d    = 1'b1;
                    mem_we_d     = ~is_read_q;
                    mem_addr_d   = dec_addr;
                    mem_wdata_d  = cpu_wdata_q;
                    mem_region_d = dec_region;
                    cnt_d        = '0;
                    state_d      = ST_WAIT;
                end else begin
                    if (is_read_q) begin
                        data_d = DATA_UNMAPPED;
                    end else begin
                        data_d = data_q;
                    end
                    ready_d = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_WAIT: begin
                if (i_Mem_Ack) begin
                    mem_req_d = 1'b0;
                    if (is_read_q) begin
                        data_d = i_Mem_Rdata;
                    end else begin
                        data_d = data_q;
                    end
                    ready_d = 1'b1;
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    mem_req_d = 1'b0;
                    if (is_read_q) begin
                        data_d = DATA_UNMAPPED;
                    end else begin
                        data_d = data_q;
                    end
                    ready_d = 1'b1;
                    error_d = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q      <= ST_IDLE;
            addr_q       <= 16'h0000;
            is_read_q    <= 1'b0;
            cpu_wdata_q  <= 8'h00;
            cnt_q        <= '0;
            data_q       <= 8'h00;
            ready_q      <= 1'b0;
            error_q      <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 16'h0000;
            mem_wdata_q  <= 8'h00;
            mem_region_q <= REG_NONE;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            is_read_q    <= is_read_d;
            cpu_wdata_q  <= cpu_wdata_d;
            cnt_q        <= cnt_d;
            data_q       <= data_d;
            ready_q      <= ready_d;
            error_q      <= error_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_region_q <= mem_region_d;
        end
    end

    assign o_Data       = data_q;
    assign o_Ready      = ready_q;
    assign o_Error      = error_q;
    assign o_Mem_Req    = mem_req_q;
    assign o_Mem_We     = mem_we_q;
    assign o_Mem_Addr   = mem_addr_q;
    assign o_Mem_Wdata  = mem_wdata_q;
    assign o_Mem_Region = mem_region_q;

endmodule

// File: tb/tb_bus_responder.sv
// tb_bus_responder
// Transaction-level model of the responder: each transaction is expanded
// into a per-cycle timeline of expected outputs, and a compare process checks
// the DUT against that timeline on every falling clock edge.
module tb_bus_responder;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        addr_out, bus_in, bus_out;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data;
    logic [7:0]  o_data;
    logic        o_ready, o_error, o_req, o_we;
    logic [15:0] o_maddr;
    logic [7:0]  o_wdata;
    logic [1:0]  o_region;
    logic        mem_ack;
    logic [7:0]  mem_rdata;

    // Expected outputs for the current cycle
    logic        exp_ready, exp_error, exp_req, exp_mem_chk, exp_we;
    logic [7:0]  exp_data, exp_wdata;
    logic [15:0] exp_maddr;
    logic [1:0]  exp_region;
    logic [7:0]  model_data;
    bit          chk_en = 1'b0;
    int          n_checks = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    bus_responder #(.TIMEOUT_CYCLES(TO)) dut (
        .i_Clk         (clk),
        .i_Reset_n     (rst_n),
        .i_Address_Out (addr_out),
        .i_Address     (cpu_addr),
        .i_Bus_In      (bus_in),
        .i_Bus_Out     (bus_out),
        .i_Data        (cpu_data),
        .o_Data        (o_data),
        .o_Ready       (o_ready),
        .o_Error       (o_error),
        .o_Mem_Req     (o_req),
        .o_Mem_We      (o_we),
        .o_Mem_Addr    (o_maddr),
        .o_Mem_Wdata   (o_wdata),
        .o_Mem_Region  (o_region),
        .i_Mem_Ack     (mem_ack),
        .i_Mem_Rdata   (mem_rdata)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Memory map of the CPU address space
    function automatic logic [1:0] region_of(input logic [15:0] a);
        if (a < 16'h8000) return 2'd0;
        if (a >= 16'hC000 && a < 16'hE000) return 2'd1;
`ifdef ECHO_RAM_EN
        if (a >= 16'hE000 && a < 16'hFE00) return 2'd1;
`endif
        if (a >= 16'hFF80 && a != 16'hFFFF) return 2'd2;
        return 2'd3;
    endfunction

    function automatic logic [15:0] translate(input logic [15:0] a);
        if (a >= 16'hE000 && a < 16'hFE00) return a - 16'h2000;
        return a;
    endfunction

    // Compare DUT outputs against the expected timeline
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready", {15'd0, o_ready}, {15'd0, exp_ready});
            chk("error", {15'd0, o_error}, {15'd0, exp_error});
            chk("mem_req", {15'd0, o_req}, {15'd0, exp_req});
            chk("data", {8'd0, o_data}, {8'd0, exp_data});
            if (exp_mem_chk) begin
                chk("mem_we", {15'd0, o_we}, {15'd0, exp_we});
                chk("mem_addr", o_maddr, exp_maddr);
                chk("mem_wdata", {8'd0, o_wdata}, {8'd0, exp_wdata});
                chk("mem_region", {14'd0, o_region}, {14'd0, exp_region});
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle_exp();
        exp_ready   = 1'b0;
        exp_error   = 1'b0;
        exp_req     = 1'b0;
        exp_mem_chk = 1'b0;
        exp_data    = model_data;
    endtask

    task automatic set_reset_exp();
        model_data  = 8'h00;
        set_idle_exp();
        exp_mem_chk = 1'b1;
        exp_we      = 1'b0;
        exp_maddr   = 16'h0000;
        exp_wdata   = 8'h00;
        exp_region  = 2'd3;
    endtask

    // Random CPU-side activity that a busy responder must ignore
    task automatic scramble();
        addr_out = 1'($urandom);
        bus_in   = 1'($urandom);
        bus_out  = 1'($urandom);
        cpu_addr = 16'($urandom);
        cpu_data = 8'($urandom);
    endtask

    // One CPU transaction; ack_at >= TO means memory never acks.
    // Entered and left at posedge+1 of an idle cycle.
    task automatic do_txn(input logic [15:0] a, input logic rd, input logic wr,
                          input logic [7:0] wd, input int ack_at, input logic [7:0] rdata);
        logic [1:0] rg;
        bit         mapped;
        bit         acked;
        addr_out = 1'b1;
        bus_in   = rd;
        bus_out  = wr;
        cpu_addr = a;
        cpu_data = wd;
        next_cycle();
        if (rd == wr) begin
            set_idle_exp();
            exp_error = 1'b1;
            addr_out  = 1'b0;
            next_cycle();
            set_idle_exp();
            return;
        end
        set_idle_exp();
        scramble();
        rg     = region_of(a);
        mapped = (rg != 2'd3) && (rd || rg != 2'd0);
        acked  = 1'b0;
        next_cycle();
        if (!mapped) begin
            if (rd) model_data = 8'hFF;
            set_idle_exp();
            exp_ready = 1'b1;
        end else begin
            for (int w = 0; w < TO; w++) begin
                set_idle_exp();
                exp_req     = 1'b1;
                exp_mem_chk = 1'b1;
                exp_we      = wr;
                exp_maddr   = translate(a);
                exp_wdata   = wd;
                exp_region  = rg;
                scramble();
                mem_ack   = (w == ack_at);
                mem_rdata = (w == ack_at) ? rdata : 8'($urandom);
                next_cycle();
                mem_ack = 1'b0;
                if (w == ack_at) begin
                    acked = 1'b1;
                    break;
                end
            end
            if (rd) model_data = acked ? rdata : 8'hFF;
            set_idle_exp();
            exp_ready = 1'b1;
            exp_error = !acked;
        end
        scramble();
        next_cycle();
        addr_out = 1'b0;
        set_idle_exp();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            next_cycle();
            set_idle_exp();
        end
    endtask

    function automatic logic [15:0] rand_addr();
        case ($urandom_range(0, 7))
            0: return 16'($urandom_range(16'h0000, 16'h7FFF));
            1: return 16'($urandom_range(16'hC000, 16'hDFFF));
            2: return 16'($urandom_range(16'hFF80, 16'hFFFE));
            3: return 16'($urandom_range(16'hE000, 16'hFDFF));
            4: return 16'($urandom_range(16'h8000, 16'hBFFF));
            5: return 16'($urandom_range(16'hFE00, 16'hFF7F));
            6: return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        rst_n = 1'b0;
        addr_out = 1'b0; bus_in = 1'b0; bus_out = 1'b0;
        cpu_addr = 16'h0000; cpu_data = 8'h00;
        mem_ack = 1'b0; mem_rdata = 8'h00;
        set_reset_exp();
        chk_en = 1'b1;

        // Model pins against hand-derived map values
        chk("pin_rom_7fff", {14'd0, region_of(16'h7FFF)}, 16'd0);
        chk("pin_none_8000", {14'd0, region_of(16'h8000)}, 16'd3);
        chk("pin_hram_fffe", {14'd0, region_of(16'hFFFE)}, 16'd2);
        chk("pin_none_ffff", {14'd0, region_of(16'hFFFF)}, 16'd3);
        chk("pin_echo_xlat", translate(16'hE010), 16'hC010);

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        next_cycle();
        set_idle_exp();

        // Read C123, ack on the third WAIT cycle
        do_txn(16'hC123, 1'b1, 1'b0, 8'h00, 2, 8'h5A);
        chk("read_c123_data", {8'd0, o_data}, 16'h005A);
        // HRAM write
        do_txn(16'hFF90, 1'b0, 1'b1, 8'h3C, 1, 8'h00);
        chk("write_keeps_data", {8'd0, o_data}, 16'h005A);
        // Unmapped read and dropped ROM write
        do_txn(16'hA000, 1'b1, 1'b0, 8'h00, 0, 8'h00);
        chk("unmapped_read_ff", {8'd0, o_data}, 16'h00FF);
        do_txn(16'h2000, 1'b0, 1'b1, 8'h01, 0, 8'h00);
        // Echo window
        do_txn(16'hE010, 1'b1, 1'b0, 8'h00, 0, 8'h77);
        // Timeout on read, then bad direction combinations
        do_txn(16'hC000, 1'b1, 1'b0, 8'h00, TO + 5, 8'h00);
        do_txn(16'h0100, 1'b1, 1'b1, 8'h00, 0, 8'h00);
        do_txn(16'h0100, 1'b0, 1'b0, 8'h00, 0, 8'h00);
        // Region edges
        do_txn(16'hFFFF, 1'b1, 1'b0, 8'h00, 0, 8'h11);
        do_txn(16'hFF80, 1'b1, 1'b0, 8'h00, TO - 1, 8'h22);
        do_txn(16'hFFFE, 1'b0, 1'b1, 8'h44, 0, 8'h00);
        do_txn(16'h7FFF, 1'b1, 1'b0, 8'h00, 3, 8'h33);
        do_txn(16'hDFFF, 1'b0, 1'b1, 8'h55, TO, 8'h00);

        // Reset during WAIT, then a stale ack
        addr_out = 1'b1; bus_in = 1'b1; bus_out = 1'b0; cpu_addr = 16'hC400;
        next_cycle(); set_idle_exp(); addr_out = 1'b0;
        next_cycle();
        rst_n = 1'b0;
        #1;
        set_reset_exp();
        next_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mem_ack   = 1'b1;
            mem_rdata = 8'hA5;
            next_cycle();
        end
        mem_ack = 1'b0;
        next_cycle();
        set_idle_exp();

        // Random traffic
        for (int t = 0; t < 300; t++) begin
            int          d;
            logic        rd, wr;
            d  = $urandom_range(0, 9);
            rd = (d == 0) ? 1'b1 : (d == 1) ? 1'b0 : d[0];
            wr = (d == 0) ? 1'b1 : (d == 1) ? 1'b0 : ~d[0];
            do_txn(rand_addr(), rd, wr, 8'($urandom),
                   $urandom_range(0, TO + 1), 8'($urandom));
            idle($urandom_range(0, 2));
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
